dffre: RTL and testbench

DFFRE -- requirements
Module: dffre

---
 rtl/dffre_pkg.sv | 13 +
 rtl/dffre.sv | 50 +++++
 tb/tb_dffre.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/dffre_pkg.sv
// Shared constants for the dffre register: width limits and default parameters.
// Ports: none (package only).
// Imported by dffre so every instance agrees on its defaults.
package dffre_pkg;

    localparam int DFFRE_MIN_WIDTH     = 1;
    localparam int DFFRE_MAX_WIDTH     = 1024;
    localparam int DFFRE_DEFAULT_WIDTH = 1;

    // Stored at the widest legal width; each instance keeps only its low WIDTH bits.
    localparam logic [DFFRE_MAX_WIDTH-1:0] DFFRE_DEFAULT_RESET = '0;

endpackage

// File: rtl/dffre.sv
// dffre: WIDTH-bit rising-edge register with load enable and asynchronous active-high reset.
// Ports: clk (clock), r (async reset, priority over all inputs), en (load enable),
//        d (data in), q (registered data, driven straight from the flops; 1-edge latency).
module dffre
    import dffre_pkg::*;
#(
    parameter int                         WIDTH       = DFFRE_DEFAULT_WIDTH,
    parameter logic [DFFRE_MAX_WIDTH-1:0] RESET_VALUE = DFFRE_DEFAULT_RESET
) (
    input  logic             clk,
    input  logic             r,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset value truncated (or zero-extended) to this instance's width.
    localparam logic [WIDTH-1:0] RST_Q = RESET_VALUE[WIDTH-1:0];

    if (WIDTH < DFFRE_MIN_WIDTH || WIDTH > DFFRE_MAX_WIDTH) begin : g_width_check
        $error("dffre: WIDTH %0d outside legal range %0d..%0d",
               WIDTH, DFFRE_MIN_WIDTH, DFFRE_MAX_WIDTH);
    end

    // The final branch is reachable only when en is X/Z in a four-state
    // simulator, so an unknown enable poisons q instead of silently holding.
    // For two-valued hardware it is a don't-care and adds no logic.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            q <= RST_Q;
        end else if (en) begin
            q <= d;
        end else if (!en) begin
            q <= q;
        end else begin
            q <= {WIDTH{1'bx}};
        end
    end

    // While reset is held, every clock edge must see the reset value.
    a_reset_value : assert property (@(posedge clk) r |-> (q == RST_Q))
        else $error("dffre: q differs from reset value while r is asserted");

    // An edge with en low must leave q untouched; a reset inside the
    // following cycle legitimately changes q and cancels the check.
    a_hold_when_disabled : assert property (
        @(posedge clk) disable iff (r) (en == 1'b0) |=> $stable(q))
        else $error("dffre: q changed across an edge with en low");

endmodule

// File: tb/tb_dffre.sv
// Directed self-checking bench for dffre: async reset, load/hold, chaining,
// reset pulse with non-zero reset value, and walking ones at widths 1 and 64.
// Ports: none (top-level bench).
module tb_dffre;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main WIDTH=4 instance, reset value 0.
    logic       r_main = 1'b0;
    logic       en4    = 1'b0;
    logic [3:0] d4     = 4'd0;
    logic [3:0] q4;

    dffre #(.WIDTH(4)) u_w4 (.clk(clk), .r(r_main), .en(en4), .d(d4), .q(q4));

    // WIDTH=4 instance with reset value A.
    logic       ra  = 1'b0;
    logic       ena = 1'b0;
    logic [3:0] da  = 4'd0;
    logic [3:0] qa;

    dffre #(.WIDTH(4), .RESET_VALUE(1024'('hA))) u_wa
        (.clk(clk), .r(ra), .en(ena), .d(da), .q(qa));

    // Five chained WIDTH=4 stages sharing one enable.
    logic       en_c = 1'b0;
    logic [3:0] dc   = 4'd0;
    logic [3:0] dcs [5];
    logic [3:0] qc  [5];

    assign dcs[0] = dc;
    for (genvar g = 0; g < 5; g++) begin : g_chain
        if (g > 0) begin : g_link
            assign dcs[g] = qc[g-1];
        end
        dffre #(.WIDTH(4)) u_stage
            (.clk(clk), .r(r_main), .en(en_c), .d(dcs[g]), .q(qc[g]));
    end

    // Width extremes used for the walking-ones pattern.
    logic        en_w = 1'b0;
    logic        d1   = 1'b0;
    logic        q1;
    logic [63:0] d64  = 64'd0;
    logic [63:0] q64;

    dffre #(.WIDTH(1))  u_w1  (.clk(clk), .r(r_main), .en(en_w), .d(d1),  .q(q1));
    dffre #(.WIDTH(64)) u_w64 (.clk(clk), .r(r_main), .en(en_w), .d(d64), .q(q64));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic edge_then_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0]  seq [5];
        logic [63:0] exp64;
        logic        exp1;

        seq[0] = 4'd4; seq[1] = 4'd5; seq[2] = 4'd9; seq[3] = 4'd10; seq[4] = 4'd14;

        // Reset asserted before the first edge with a live load pending.
        #2;
        r_main = 1'b1;
        ra     = 1'b1;
        en4    = 1'b1;
        d4     = 4'd4;
        #1;
        chk("rst_async_q4", 64'(q4), 64'h0);
        chk("rst_async_qa", 64'(qa), 64'hA);
        chk("rst_async_chain5", 64'(qc[4]), 64'h0);
        chk("rst_async_q64", q64, 64'h0);

        // Clock runs under reset: values must not move.
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold_q4", 64'(q4), 64'h0);
        chk("rst_hold_qa", 64'(qa), 64'hA);

        // Release mid-cycle: no stale d before the next edge.
        r_main = 1'b0;
        ra     = 1'b0;
        #1;
        chk("release_no_stale", 64'(q4), 64'h0);

        edge_then_settle();
        chk("load_4", 64'(q4), 64'h4);
        #2;
        d4 = 4'd5;
        #1;
        chk("mid_cycle_d_hold", 64'(q4), 64'h4);
        edge_then_settle();
        chk("load_5", 64'(q4), 64'h5);

        // Load 9, then disable and toggle d across 0..15 for 8 edges.
        d4 = 4'd9;
        edge_then_settle();
        chk("load_9", 64'(q4), 64'h9);
        en4 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            d4 = 4'(2 * i);
            #2;
            d4 = 4'(2 * i + 1);
            edge_then_settle();
            chk("hold_en0", 64'(q4), 64'h9);
        end
        en4 = 1'b1;
        d4  = 4'd3;
        edge_then_settle();
        chk("reenable_load_3", 64'(q4), 64'h3);

        // Reset value A: load 7, then a 2 ns reset pulse between edges.
        ena = 1'b1;
        da  = 4'd7;
        edge_then_settle();
        chk("qa_load_7", 64'(qa), 64'h7);
        #2;
        ra  = 1'b1;
        ena = 1'b0;
        #1;
        chk("qa_pulse_async", 64'(qa), 64'hA);
        #1;
        ra = 1'b0;
        edge_then_settle();
        chk("qa_hold_a_1", 64'(qa), 64'hA);
        edge_then_settle();
        chk("qa_hold_a_2", 64'(qa), 64'hA);
        ena = 1'b1;
        edge_then_settle();
        chk("qa_first_load", 64'(qa), 64'h7);

        // Chain: feed 4,5,9,10,14 one per edge.
        en_c = 1'b1;
        for (int k = 0; k < 5; k++) begin
            dc = seq[k];
            edge_then_settle();
            if (k == 0) begin
                chk("chain_e1_stage1", 64'(qc[0]), 64'h4);
                chk("chain_e1_stage2", 64'(qc[1]), 64'h0);
            end
            if (k == 3) begin
                chk("chain_e4_stage5", 64'(qc[4]), 64'h0);
            end
        end
        chk("chain_stage1", 64'(qc[0]), 64'hE);
        chk("chain_stage2", 64'(qc[1]), 64'hA);
        chk("chain_stage3", 64'(qc[2]), 64'h9);
        chk("chain_stage4", 64'(qc[3]), 64'h5);
        chk("chain_stage5", 64'(qc[4]), 64'h4);
        en_c = 1'b0;

        // Walking ones on the 64-bit and 1-bit instances.
        en_w = 1'b1;
        for (int i = 0; i < 64; i++) begin
            exp64 = 64'd1 << i;
            exp1  = (i % 2 == 0);
            d64   = exp64;
            d1    = exp1;
            #1;
            if (i > 0) begin
                chk("walk64_pre_edge", q64, 64'd1 << (i - 1));
            end
            edge_then_settle();
            chk("walk64", q64, exp64);
            chk("walk1", 64'(q1), 64'(exp1));
        end
        en_w = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
